muldiv_unit: RTL

//  Multi-cycle multiply/divide engine for the pipelined MIPS core, driven by the decoder's

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the decode stage and the
// multiply/divide engine.
//   start_i/div_i/sign_i/annul_i : op request, op kind, signedness, cancel
//   a_i/b_i                      : rs/rt operands
//   stall_o                      : hold the pipeline (combinational)
//   valid_o                      : one-cycle result strobe
//   hi_o/lo_o                    : HI/LO write-back values
// master = decoder side, slave = muldiv_unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             start_i;
    logic             div_i;
    logic             sign_i;
    logic             annul_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             stall_o;
    logic             valid_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (output start_i, div_i, sign_i, annul_i, a_i, b_i,
                    input  stall_o, valid_o, hi_o, lo_o);
    modport slave  (input  start_i, div_i, sign_i, annul_i, a_i, b_i,
                    output stall_o, valid_o, hi_o, lo_o);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine for the MIPS pipeline.
// Multiply: product formed at accept, DONE after MUL_LAT cycles.
// Divide: radix-2 restoring, one quotient bit per cycle, DONE at WIDTH+1.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     muldiv_unit_if.slave (request in, stall/valid/hi/lo out)
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            resetn,
    muldiv_unit_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   quo;      // dividend shifting out / quotient shifting in; product low
    logic [WIDTH-1:0]   rem;      // partial remainder; product high
    logic [WIDTH-1:0]   dvs;      // divisor magnitude
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   hold_hi;
    logic [WIDTH-1:0]   hold_lo;

    logic               accept;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH:0]     rem_sh, rem_sub;
    logic               fits;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               live;

    assign accept = (state == IDLE) && bus.start_i && !bus.annul_i;

    assign a_neg = bus.sign_i && bus.a_i[WIDTH-1];
    assign b_neg = bus.sign_i && bus.b_i[WIDTH-1];
    assign a_mag = a_neg ? -bus.a_i : bus.a_i;
    assign b_mag = b_neg ? -bus.b_i : bus.b_i;

    // Sign/zero extension to 2W makes one truncated 2W multiply serve both
    // MULT and MULTU.
    assign a_ext = {{WIDTH{a_neg}}, bus.a_i};
    assign b_ext = {{WIDTH{b_neg}}, bus.b_i};
    assign prod  = a_ext * b_ext;

    // Restoring step: bring in the next dividend bit, keep the subtract if it fits.
    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign fits    = rem_sh >= {1'b0, dvs};
    assign rem_sub = rem_sh - {1'b0, dvs};

    // Sign fix-up happens only in DONE; the flags are clear for MUL and /0.
    assign res_hi = neg_r ? -rem : rem;
    assign res_lo = neg_q ? -quo : quo;

    // Annul in DONE must suppress both the strobe and the new values, so the
    // fresh result is muxed onto hi/lo only while the strobe is live.
    assign live        = (state == DONE) && !bus.annul_i;
    assign bus.valid_o = live;
    assign bus.hi_o    = live ? res_hi : hold_hi;
    assign bus.lo_o    = live ? res_lo : hold_lo;
    assign bus.stall_o = accept || (((state == MUL) || (state == DIV)) && !bus.annul_i);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hold_hi <= '0;
            hold_lo <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (!bus.div_i) begin
                        {rem, quo} <= prod;
                        neg_q      <= 1'b0;
                        neg_r      <= 1'b0;
                        cnt        <= CW'(1);
                        state      <= (MUL_LAT == 1) ? DONE : MUL;
                    end else if (bus.b_i == '0) begin
                        // Divide by zero: no iteration, raw dividend as remainder.
                        quo   <= '1;
                        rem   <= bus.a_i;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= DONE;
                    end else begin
                        quo   <= a_mag;
                        rem   <= '0;
                        dvs   <= b_mag;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                MUL: begin
                    if (bus.annul_i)          state <= IDLE;
                    else if (cnt == MUL_LAST) state <= DONE;
                    else                      cnt   <= cnt + 1'b1;
                end
                DIV: begin
                    if (bus.annul_i) begin
                        state <= IDLE;
                    end else begin
                        rem <= fits ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], fits};
                        cnt <= cnt + 1'b1;
                        if (cnt == DIV_LAST) state <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.annul_i) begin
                        hold_hi <= res_hi;
                        hold_lo <= res_lo;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
